// File: rtl/uart_host_rx.sv
// uart_host_rx: host-side 8N1 UART receiver with a small receive FIFO.
// Decodes frames from the CPU Tx line and hands bytes out over valid/ready.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   rx_in       serial line (idles high), asynchronous to clk
//   dout        byte at the FIFO head
//   dout_valid  FIFO not empty
//   dout_ready  consumer accepts dout this cycle
//   frame_err   one-cycle pulse: stop bit sampled low
//   overflow    one-cycle pulse: byte dropped, FIFO full
//   busy        receiver not in IDLE
//   fifo_count  bytes currently held
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits, LSB first, at mid-bit
// STOP  | sampling stop bit, pushing or flagging the byte
// BREAK | stop bit was low; wait for line to return high
module uart_host_rx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_in,
  output logic [7:0]               dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     frame_err,
  output logic                     overflow,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CNTW  = FIFO_DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t            state_q;
  logic              rx_meta_q, rx_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic [7:0]        mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CNTW-1:0]   count_q, count_d;
  logic              frame_err_q, overflow_q;

  logic stop_sample, push, pop, full, wr_en;

  // Counters run down; each phase acts when its counter reaches zero.
  assign stop_sample = (state_q == STOP) && (cnt_q == '0);
  assign push        = stop_sample && rx_q;
  assign pop         = (count_q != '0) && dout_ready;
  assign full        = (count_q == FULL_CNT);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_en       = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_q        <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_meta_q   <= rx_in;
      rx_q        <= rx_meta_q;
      frame_err_q <= stop_sample && !rx_q;
      overflow_q  <= push && !wr_en;

      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;

      case (state_q)
        IDLE: begin
          if (!rx_q) begin
            state_q <= START;
            cnt_q   <= HALF_LD;
          end
        end
        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!rx_q) begin
            state_q   <= DATA;
            cnt_q     <= BIT_LD;
            bit_idx_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shift_q <= {rx_q, shift_q[7:1]};
            cnt_q   <= BIT_LD;
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        STOP: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else state_q <= rx_q ? IDLE : BREAK;
        end
        BREAK: begin
          if (rx_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_host_rx.sv
// Directed bench for uart_host_rx with CLKS_PER_BIT = 16, depth 4.
module tb_uart_host_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       overflow;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] rxq[$];
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int q0, fe0, ov0, v0;

  uart_host_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_err(frame_err), .overflow(overflow), .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid) valid_cycles++;
      if (dout_valid && dout_ready) rxq.push_back(dout);
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] qbyte(input int idx);
    if (idx < rxq.size()) return {24'd0, rxq[idx]};
    return 32'hDEAD;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      cycles(CPB);
    end
    rx_in = 1'b1;
  endtask

  task automatic mark();
    q0 = rxq.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    v0 = valid_cycles;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_in = 1'b1;
    dout_ready = 1'b1;
    cycles(3);
    check("rst_valid", dout_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    cycles(5);

    // 1: single byte, ready high
    mark();
    send_byte(8'hA5, 1'b1);
    cycles(4);
    check("t1_nbytes", rxq.size() - q0, 1);
    check("t1_byte", qbyte(q0), 8'hA5);
    check("t1_valid_cycles", valid_cycles - v0, 1);
    check("t1_ferr", fe_cnt - fe0, 0);
    check("t1_busy", busy, 0);
    check("t1_count", fifo_count, 0);

    // 2: false start
    mark();
    rx_in = 1'b0;
    cycles(4);
    rx_in = 1'b1;
    cycles(30);
    check("t2_nbytes", rxq.size() - q0, 0);
    check("t2_ferr", fe_cnt - fe0, 0);
    check("t2_busy", busy, 0);
    check("t2_count", fifo_count, 0);

    // 3: framing error, held break, recovery
    mark();
    send_byte(8'h3C, 1'b0);
    rx_in = 1'b0;
    cycles(40);
    check("t3_busy_break", busy, 1);
    rx_in = 1'b1;
    cycles(20);
    check("t3_idle", busy, 0);
    send_byte(8'h11, 1'b1);
    cycles(4);
    check("t3_ferr", fe_cnt - fe0, 1);
    check("t3_nbytes", rxq.size() - q0, 1);
    check("t3_byte", qbyte(q0), 8'h11);

    // 4: fill FIFO, overflow, drain
    mark();
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
      cycles(2);
    end
    check("t4_count_full", fifo_count, 4);
    check("t4_ovf", ov_cnt - ov0, 1);
    check("t4_ferr", fe_cnt - fe0, 0);
    check("t4_valid", dout_valid, 1);
    check("t4_head", dout, 8'h01);
    dout_ready = 1'b1;
    cycles(8);
    check("t4_nbytes", rxq.size() - q0, 4);
    for (int i = 0; i < 4; i++) check("t4_drain", qbyte(q0 + i), i + 1);
    check("t4_count_empty", fifo_count, 0);

    // 5: back-to-back frames
    mark();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    cycles(4);
    check("t5_nbytes", rxq.size() - q0, 2);
    check("t5_b0", qbyte(q0), 8'h00);
    check("t5_b1", qbyte(q0 + 1), 8'hFF);
    check("t5_ferr", fe_cnt - fe0, 0);
    check("t5_ovf", ov_cnt - ov0, 0);

    // 6: reset mid-frame with a byte held in the FIFO
    dout_ready = 1'b0;
    send_byte(8'h77, 1'b1);
    cycles(4);
    check("t6_pre_count", fifo_count, 1);
    rx_in = 1'b0;                 // start bit of 0x5A
    cycles(CPB);
    rx_in = 1'b0; cycles(CPB);    // bit0
    rx_in = 1'b1; cycles(CPB);    // bit1
    rx_in = 1'b0; cycles(CPB);    // bit2
    rx_in = 1'b1; cycles(CPB / 2); // into bit3
    check("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    cycles(1);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_valid", dout_valid, 0);
    check("t6_rst_dout", dout, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ferr", frame_err, 0);
    check("t6_rst_ovf", overflow, 0);
    rst_n = 1'b1;
    cycles(40);
    check("t6_idle", busy, 0);
    dout_ready = 1'b1;
    mark();
    send_byte(8'hC3, 1'b1);
    cycles(5);
    check("t6_nbytes", rxq.size() - q0, 1);
    check("t6_byte", qbyte(q0), 8'hC3);
    check("t6_ferr", fe_cnt - fe0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_host_rx.md
Name: uart_host_rx

Overview:
- Host-side UART receiver that sits at the far end of the CPU top-level serial Tx line and decodes its 8N1 frames.
- Samples the serial line, validates start and stop bits, and buffers received bytes in a small FIFO.
- Hands bytes out through a valid/ready interface.
- Used in simulation benches and FPGA loopback harnesses to capture program output.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 4.
- FIFO_DEPTH_LOG2, 2, log2 of receive FIFO depth (default depth 4).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- rx_in  input  1  serial line from CPU Tx; idles high; asynchronous to clk.
- dout  output  8  byte at the FIFO head.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer accepts dout this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overflow  output  1  one-cycle pulse: byte dropped because the FIFO was full.
- busy  output  1  high in any state other than IDLE.
- fifo_count  output  FIFO_DEPTH_LOG2+1  number of bytes held.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; 2-FF synchroniser flops = 1.
  - FIFO emptied: dout_valid = 0, fifo_count = 0, dout = 0x00.
  - frame_err = 0, overflow = 0, busy = 0.
  - Bit counter and shift register cleared.
  - A reset mid-frame aborts the frame; no partial byte is pushed.
- rx_in passes through a 2-FF synchroniser; "rx" below means the synchronised value (2-cycle delay).
- IDLE: rx == 0 -> START, cycle counter = 0.
- START: count to CLKS_PER_BIT/2 - 1 (integer floor).
  - At terminal count, rx == 0 -> DATA, counter = 0, bit index = 0.
  - rx == 1 -> false start, back to IDLE; no error flagged.
- DATA: every CLKS_PER_BIT cycles, shift rx into the shift register, LSB first.
  - After bit 7 is sampled -> STOP, counter = 0.
- STOP: sample rx after CLKS_PER_BIT cycles.
  - rx == 1: push the byte, go to IDLE.
    - If the FIFO is full and not popped in the same cycle, drop the byte and pulse overflow instead.
  - rx == 0: pulse frame_err, discard the byte, go to BREAK.
- BREAK: wait until rx == 1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Push latency: byte visible on dout / dout_valid the cycle after the stop-bit sample edge.
- FIFO:
  - Circular buffer with rd/wr pointers; wrap modulo depth.
  - Pop when dout_valid && dout_ready.
  - Simultaneous push and pop when full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop when empty: push only (dout_valid was 0).
  - dout is don't-care when dout_valid = 0, but must not change while valid && !ready.
- fifo_count = pushes - pops; maximum is 2^FIFO_DEPTH_LOG2.
- Back-to-back frames: a start bit immediately after the stop-bit sample is detected in IDLE the next cycle.
- frame_err and overflow are never asserted in the same cycle.

Test Plan (CLKS_PER_BIT = 16, FIFO_DEPTH_LOG2 = 2):
1. Send 0xA5 8N1 with dout_ready = 1 -> dout_valid for exactly 1 cycle with dout = 0xA5; frame_err = 0; busy drops after stop sample; fifo_count returns to 0.
2. Drive rx_in low for 4 cycles, then high -> no push, no frame_err, state back in IDLE, fifo_count = 0.
3. Send 0x3C with stop bit 0, hold line low 40 more cycles, release, then send 0x11 -> one frame_err pulse; no 0x3C pushed; 0x11 received correctly.
4. Hold dout_ready = 0 and send 0x01..0x05 -> fifo_count = 4; one overflow pulse on 0x05. Then raise ready -> drains 0x01, 0x02, 0x03, 0x04 in order.
5. Send 0x00 and 0xFF back-to-back with zero idle bits -> both received in order, no errors.
6. Assert rst_n = 0 during data bit 3 of 0x5A, release, send 0xC3 -> all outputs at reset values after the reset edge; only 0xC3 is received.
